// File: rtl/anc_pkg.sv
// Shared types and constants for the ANC sample sequencer.
// Holds the FSM state encoding, Q1.15 limits and the default WAIT timeout.
package anc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_GO   = 2'd2,
    ST_WAIT = 2'd3
  } anc_state_e;

  localparam logic signed [15:0] Q15_MAX = 16'sh7FFF;
  localparam logic signed [15:0] Q15_MIN = 16'sh8000;

  localparam int DEFAULT_TIMEOUT = 512;

endpackage

// File: rtl/bw_mult.sv
// 16x16 signed multiplier returning the full 32-bit product.
module bw_mult (
  input  logic signed [15:0] a_i,
  input  logic signed [15:0] b_i,
  output logic signed [31:0] p_o
);

  assign p_o = a_i * b_i;

endmodule

// File: rtl/saturate.sv
// Signed saturating narrowing from IW bits to OW bits.
module saturate #(
  parameter int IW = 17,
  parameter int OW = 16
) (
  input  logic signed [IW-1:0] in_i,
  output logic signed [OW-1:0] out_o
);

  localparam logic signed [IW-1:0] MAX_V = IW'((64'sd1 <<< (OW-1)) - 64'sd1);
  localparam logic signed [IW-1:0] MIN_V = IW'(-(64'sd1 <<< (OW-1)));

  always_comb begin
    out_o = in_i[OW-1:0];
    if (in_i > MAX_V) begin
      out_o = MAX_V[OW-1:0];
    end else if (in_i < MIN_V) begin
      out_o = MIN_V[OW-1:0];
    end
  end

endmodule

// File: rtl/anc_ctrl.sv
// Sample-rate sequencer for the adaptive FIR: computes the LMS weight step,
// launches one FIR run per accepted sample and forwards the result.
module anc_ctrl
  import anc_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          smp_valid,
  input  logic [15:0]   ref_in,
  input  logic [15:0]   err_in,
  input  logic [15:0]   mix_in,
  input  logic [15:0]   mu,
  output logic [15:0]   fir_x,
  output logic [15:0]   fir_a,
  output logic [15:0]   fir_wadj,
  output logic          fir_go,
  input  logic [15:0]   fir_out,
  input  logic          fir_out_valid,
  input  logic          fir_done,
  output logic [15:0]   spk_out,
  output logic          spk_valid,
  output logic          busy,
  output logic          overrun,
  output logic [CW-1:0] overrun_cnt,
  output logic          timeout_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  anc_state_e     state_q;
  logic [15:0]    ref_q, err_q, mix_q, mu_q;
  logic [15:0]    fir_x_q, fir_a_q, fir_wadj_q;
  logic           fir_go_q;
  logic [15:0]    spk_out_q;
  logic           spk_valid_q;
  logic           overrun_q;
  logic [CW-1:0]  overrun_cnt_q, overrun_cnt_d;
  logic           timeout_err_q;
  logic [TW-1:0]  tmo_cnt_q;

  logic signed [31:0] prod;
  logic signed [15:0] wadj_sat;

  bw_mult u_mult (
    .a_i (mu_q),
    .b_i (err_q),
    .p_o (prod)
  );

  // Product bits [31:15] are the Q1.15 result with one guard bit for clipping.
  saturate #(.IW(17), .OW(16)) u_sat (
    .in_i  (prod[31:15]),
    .out_o (wadj_sat)
  );

  always_comb begin
    overrun_cnt_d = overrun_cnt_q;
    if (overrun_cnt_q != '1) begin
      overrun_cnt_d = overrun_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ref_q         <= '0;
      err_q         <= '0;
      mix_q         <= '0;
      mu_q          <= '0;
      fir_x_q       <= '0;
      fir_a_q       <= '0;
      fir_wadj_q    <= '0;
      fir_go_q      <= 1'b0;
      spk_out_q     <= '0;
      spk_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
      overrun_cnt_q <= '0;
      timeout_err_q <= 1'b0;
      tmo_cnt_q     <= '0;
    end else begin
      fir_go_q    <= 1'b0;
      spk_valid_q <= 1'b0;
      overrun_q   <= 1'b0;

      // Any sample arriving outside IDLE is lost, regardless of enable.
      if (smp_valid && (state_q != ST_IDLE)) begin
        overrun_q     <= 1'b1;
        overrun_cnt_q <= overrun_cnt_d;
      end

      case (state_q)
        ST_IDLE: begin
          if (smp_valid && enable) begin
            ref_q   <= ref_in;
            err_q   <= err_in;
            mix_q   <= mix_in;
            mu_q    <= mu;
            state_q <= ST_MUL;
          end
        end
        ST_MUL: begin
          fir_wadj_q <= wadj_sat;
          fir_x_q    <= ref_q;
          fir_a_q    <= mix_q;
          fir_go_q   <= 1'b1;
          state_q    <= ST_GO;
        end
        ST_GO: begin
          tmo_cnt_q <= '0;
          state_q   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (fir_done) begin
            if (fir_out_valid) begin
              spk_out_q   <= fir_out;
              spk_valid_q <= 1'b1;
            end
            state_q <= ST_IDLE;
          end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
            timeout_err_q <= 1'b1;
            state_q       <= ST_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign fir_x       = fir_x_q;
  assign fir_a       = fir_a_q;
  assign fir_wadj    = fir_wadj_q;
  assign fir_go      = fir_go_q;
  assign spk_out     = spk_out_q;
  assign spk_valid   = spk_valid_q;
  assign overrun     = overrun_q;
  assign overrun_cnt = overrun_cnt_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_anc_ctrl.sv
// Self-checking bench for anc_ctrl: the FIR handshake is stubbed inline and
// speaker results are checked through an expected queue.
module tb_anc_ctrl;

  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          smp_valid;
  logic [15:0]   ref_in, err_in, mix_in, mu;
  logic [15:0]   fir_x, fir_a, fir_wadj;
  logic          fir_go;
  logic [15:0]   fir_out;
  logic          fir_out_valid;
  logic          fir_done;
  logic [15:0]   spk_out;
  logic          spk_valid;
  logic          busy;
  logic          overrun;
  logic [CW-1:0] overrun_cnt;
  logic          timeout_err;

  int vec_cnt    = 0;
  int miscmp_cnt = 0;

  logic [15:0]   exp_q[$];
  logic [15:0]   last_spk;
  logic [CW-1:0] exp_ovr;

  anc_ctrl #(.TIMEOUT(512), .CW(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .smp_valid     (smp_valid),
    .ref_in        (ref_in),
    .err_in        (err_in),
    .mix_in        (mix_in),
    .mu            (mu),
    .fir_x         (fir_x),
    .fir_a         (fir_a),
    .fir_wadj      (fir_wadj),
    .fir_go        (fir_go),
    .fir_out       (fir_out),
    .fir_out_valid (fir_out_valid),
    .fir_done      (fir_done),
    .spk_out       (spk_out),
    .spk_valid     (spk_valid),
    .busy          (busy),
    .overrun       (overrun),
    .overrun_cnt   (overrun_cnt),
    .timeout_err   (timeout_err)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1 && spk_valid === 1'b1) begin
      vec_cnt++;
      if (exp_q.size() == 0) begin
        miscmp_cnt++;
        $display("FAIL spk_unexpected: got spk_valid with spk_out=%h, required no strobe", spk_out);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (spk_out !== e) begin
          miscmp_cnt++;
          $display("FAIL spk_out: got %h, required %h", spk_out, e);
        end
      end
    end
  end

  // ---------------- model ----------------
  function automatic logic [15:0] model_wadj(input logic [15:0] m, input logic [15:0] e);
    int p;
    p = $signed(m) * $signed(e);
    p = p >>> 15;
    if (p > 32767)  return 16'h7FFF;
    if (p < -32768) return 16'h8000;
    return p[15:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives a one-cycle sample; returns in cycle 1 relative to the strobe.
  task automatic send_sample(input logic [15:0] r, input logic [15:0] e,
                             input logic [15:0] x, input logic [15:0] m);
    ref_in    = r;
    err_in    = e;
    mix_in    = x;
    mu        = m;
    smp_valid = 1'b1;
    step();
    smp_valid = 1'b0;
  endtask

  task automatic wait_go(output int c);
    c = 1;
    while (fir_go !== 1'b1 && c < 8) begin
      step();
      c++;
    end
  endtask

  // Called in the fir_go cycle; asserts done dly cycles later, returns at done+1.
  task automatic finish_run(input int dly, input logic [15:0] out, input logic vld);
    repeat (dly) step();
    fir_done      = 1'b1;
    fir_out_valid = vld;
    fir_out       = out;
    if (vld) begin
      exp_q.push_back(out);
      last_spk = out;
    end
    step();
    fir_done      = 1'b0;
    fir_out_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; smp_valid = 1'b0;
    ref_in = '0; err_in = '0; mix_in = '0; mu = '0;
    fir_out = '0; fir_out_valid = 1'b0; fir_done = 1'b0;
    last_spk = '0; exp_ovr = '0;
    repeat (3) step();
    vec_cnt++;
    if ({fir_x, fir_a, fir_wadj, fir_go, spk_out, spk_valid, busy, overrun, overrun_cnt, timeout_err} !== '0) begin
      miscmp_cnt++;
      $display("FAIL reset_outputs: got x=%h a=%h w=%h go=%b spk=%h sv=%b busy=%b ov=%b cnt=%h to=%b, required all zero",
               fir_x, fir_a, fir_wadj, fir_go, spk_out, spk_valid, busy, overrun, overrun_cnt, timeout_err);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int c;
    send_sample(16'h4000, 16'h2000, 16'h0100, 16'h4000);
    vec_cnt++;
    if (busy !== 1'b1 || fir_go !== 1'b0) begin
      miscmp_cnt++;
      $display("FAIL basic_cycle1: got busy=%b go=%b, required busy=1 go=0", busy, fir_go);
    end
    step();
    c = 2;
    vec_cnt++;
    if (fir_go !== 1'b1) begin
      miscmp_cnt++;
      $display("FAIL basic_go_cycle2: got fir_go=%b in cycle %0d, required 1", fir_go, c);
    end
    vec_cnt++;
    if ({fir_wadj, fir_x, fir_a} !== {16'h1000, 16'h4000, 16'h0100}) begin
      miscmp_cnt++;
      $display("FAIL basic_fir_data: got w=%h x=%h a=%h, required w=1000 x=4000 a=0100", fir_wadj, fir_x, fir_a);
    end
    step();
    vec_cnt++;
    if (fir_go !== 1'b0) begin
      miscmp_cnt++;
      $display("FAIL basic_go_width: got fir_go=%b in cycle 3, required 0", fir_go);
    end
    finish_run(262, 16'h1234, 1'b1);
    vec_cnt++;
    if (spk_valid !== 1'b1 || spk_out !== 16'h1234 || busy !== 1'b0) begin
      miscmp_cnt++;
      $display("FAIL basic_done_plus1: got sv=%b spk=%h busy=%b, required sv=1 spk=1234 busy=0", spk_valid, spk_out, busy);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] m_t[4];
    logic [15:0] e_t[4];
    int c;
    m_t[0] = 16'h8000; e_t[0] = 16'h8000;
    m_t[1] = 16'h7FFF; e_t[1] = 16'h8000;
    m_t[2] = 16'h0000; e_t[2] = 16'h7123;
    m_t[3] = 16'hC000; e_t[3] = 16'h4000;
    for (int i = 0; i < 10; i++) begin
      logic [15:0] m, e, r, x, ew, out;
      if (i < 4) begin
        m = m_t[i]; e = e_t[i];
      end else begin
        m = 16'($urandom_range(0, 16'hFFFF));
        e = 16'($urandom_range(0, 16'hFFFF));
      end
      r   = 16'($urandom_range(0, 16'hFFFF));
      x   = 16'($urandom_range(0, 16'hFFFF));
      out = 16'($urandom_range(0, 16'hFFFF));
      ew  = model_wadj(m, e);
      if (i == 0) ew = 16'h7FFF;
      if (i == 1) ew = 16'h8001;
      if (i == 2) ew = 16'h0000;
      send_sample(r, e, x, m);
      wait_go(c);
      vec_cnt++;
      if (c != 2 || {fir_wadj, fir_x, fir_a} !== {ew, r, x}) begin
        miscmp_cnt++;
        $display("FAIL sat_wadj[%0d]: got go_cycle=%0d w=%h x=%h a=%h, required go_cycle=2 w=%h x=%h a=%h",
                 i, c, fir_wadj, fir_x, fir_a, ew, r, x);
      end
      finish_run(5 + i, out, 1'b1);
    end
  endtask

  task automatic test_overrun();
    int cyc;
    int pulses;
    pulses = 0;
    send_sample(16'h1111, 16'h0800, 16'h0022, 16'h2000);
    cyc = 1;
    while (cyc < 265) begin
      if (cyc == 10 || cyc == 100) begin
        smp_valid = 1'b1; ref_in = 16'h7777; err_in = 16'h7FFF; mix_in = 16'h5555; mu = 16'h7FFF;
      end else begin
        smp_valid = 1'b0;
      end
      step();
      cyc++;
      if (overrun === 1'b1) pulses++;
    end
    smp_valid = 1'b1;
    ref_in = 16'h6666;
    fir_done = 1'b1; fir_out_valid = 1'b1; fir_out = 16'h0BEE;
    exp_q.push_back(16'h0BEE);
    last_spk = 16'h0BEE;
    step();
    smp_valid = 1'b0; fir_done = 1'b0; fir_out_valid = 1'b0;
    if (overrun === 1'b1) pulses++;
    exp_ovr = exp_ovr + 3;
    vec_cnt++;
    if (pulses != 3 || overrun_cnt !== exp_ovr) begin
      miscmp_cnt++;
      $display("FAIL overrun_count: got pulses=%0d cnt=%0d, required pulses=3 cnt=%0d", pulses, overrun_cnt, exp_ovr);
    end
    vec_cnt++;
    if ({fir_x, fir_a, fir_wadj} !== {16'h1111, 16'h0022, 16'h0200}) begin
      miscmp_cnt++;
      $display("FAIL overrun_latched: got x=%h a=%h w=%h, required x=1111 a=0022 w=0200", fir_x, fir_a, fir_wadj);
    end
    send_sample(16'h0ABC, 16'h1000, 16'h0033, 16'h1000);
    vec_cnt++;
    if (busy !== 1'b1 || overrun !== 1'b0) begin
      miscmp_cnt++;
      $display("FAIL overrun_accept_d1: got busy=%b overrun=%b, required busy=1 overrun=0", busy, overrun);
    end
    step();
    vec_cnt++;
    if (fir_go !== 1'b1 || fir_x !== 16'h0ABC || fir_wadj !== 16'h0200) begin
      miscmp_cnt++;
      $display("FAIL overrun_next_run: got go=%b x=%h w=%h, required go=1 x=0abc w=0200", fir_go, fir_x, fir_wadj);
    end
    finish_run(12, 16'h2222, 1'b1);
  endtask

  task automatic test_back_to_back();
    int c;
    send_sample(16'h0101, 16'h4000, 16'h0202, 16'h4000);
    wait_go(c);
    finish_run(20, 16'h3333, 1'b0);
    vec_cnt++;
    if (spk_valid !== 1'b0 || spk_out !== last_spk || busy !== 1'b0) begin
      miscmp_cnt++;
      $display("FAIL b2b_no_valid: got sv=%b spk=%h busy=%b, required sv=0 spk=%h busy=0", spk_valid, spk_out, busy, last_spk);
    end
    for (int i = 0; i < 3; i++) begin
      logic [15:0] r;
      r = 16'($urandom_range(0, 16'hFFFF));
      send_sample(r, 16'h2000, 16'h0404, 16'h2000);
      vec_cnt++;
      if (busy !== 1'b1) begin
        miscmp_cnt++;
        $display("FAIL b2b_accept[%0d]: got busy=%b, required 1", i, busy);
      end
      wait_go(c);
      vec_cnt++;
      if (c != 2 || fir_x !== r || fir_wadj !== 16'h0800) begin
        miscmp_cnt++;
        $display("FAIL b2b_run[%0d]: got go_cycle=%0d x=%h w=%h, required 2 %h 0800", i, c, fir_x, fir_wadj, r);
      end
      finish_run(8 + 3 * i, 16'($urandom_range(0, 16'hFFFF)), 1'b1);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    int c;
    send_sample(16'h5A5A, 16'h0100, 16'h0055, 16'h0100);
    cyc = 1;
    while (cyc < 514) begin
      step();
      cyc++;
    end
    vec_cnt++;
    if (busy !== 1'b1 || timeout_err !== 1'b0) begin
      miscmp_cnt++;
      $display("FAIL timeout_early: got busy=%b to=%b at cycle 514, required busy=1 to=0", busy, timeout_err);
    end
    step();
    vec_cnt++;
    if (busy !== 1'b0 || timeout_err !== 1'b1 || spk_valid !== 1'b0 || spk_out !== last_spk) begin
      miscmp_cnt++;
      $display("FAIL timeout_abort: got busy=%b to=%b sv=%b spk=%h, required busy=0 to=1 sv=0 spk=%h",
               busy, timeout_err, spk_valid, spk_out, last_spk);
    end
    fir_done = 1'b1; fir_out_valid = 1'b1; fir_out = 16'hDEAD;
    step();
    fir_done = 1'b0; fir_out_valid = 1'b0;
    step();
    vec_cnt++;
    if (spk_valid !== 1'b0 || spk_out !== last_spk || busy !== 1'b0 || fir_go !== 1'b0) begin
      miscmp_cnt++;
      $display("FAIL timeout_stray_done: got sv=%b spk=%h busy=%b go=%b, required 0 %h 0 0",
               spk_valid, spk_out, busy, fir_go, last_spk);
    end
    send_sample(16'h1357, 16'h4000, 16'h2468, 16'h4000);
    wait_go(c);
    vec_cnt++;
    if (c != 2 || fir_x !== 16'h1357 || fir_wadj !== 16'h2000 || timeout_err !== 1'b1) begin
      miscmp_cnt++;
      $display("FAIL timeout_recover: got go_cycle=%0d x=%h w=%h to=%b, required 2 1357 2000 1", c, fir_x, fir_wadj, timeout_err);
    end
    finish_run(30, 16'h4444, 1'b1);
  endtask

  task automatic test_reset_mid();
    int gos;
    int c;
    send_sample(16'h7070, 16'h3000, 16'h0707, 16'h3000);
    repeat (50) step();
    #2;
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({fir_x, fir_a, fir_wadj, fir_go, spk_out, spk_valid, busy, overrun, overrun_cnt, timeout_err} !== '0) begin
      miscmp_cnt++;
      $display("FAIL reset_async: got x=%h a=%h w=%h go=%b spk=%h sv=%b busy=%b ov=%b cnt=%h to=%b, required all zero",
               fir_x, fir_a, fir_wadj, fir_go, spk_out, spk_valid, busy, overrun, overrun_cnt, timeout_err);
    end
    last_spk = '0;
    exp_ovr  = '0;
    step();
    step();
    rst_n = 1'b1;
    gos = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (fir_go === 1'b1 || busy === 1'b1) gos++;
    end
    vec_cnt++;
    if (gos != 0) begin
      miscmp_cnt++;
      $display("FAIL reset_no_go: got %0d cycles with go/busy after reset, required 0", gos);
    end
    send_sample(16'h0F0F, 16'h8000, 16'h00F0, 16'h8000);
    wait_go(c);
    vec_cnt++;
    if (c != 2 || fir_wadj !== 16'h7FFF || fir_x !== 16'h0F0F) begin
      miscmp_cnt++;
      $display("FAIL reset_recover: got go_cycle=%0d w=%h x=%h, required 2 7fff 0f0f", c, fir_wadj, fir_x);
    end
    finish_run(40, 16'h5555, 1'b1);
  endtask

  task automatic test_enable();
    int gos;
    int c;
    enable = 1'b0;
    send_sample(16'h1111, 16'h1111, 16'h1111, 16'h1111);
    gos = 0;
    for (int i = 0; i < 6; i++) begin
      if (fir_go === 1'b1 || busy === 1'b1 || overrun === 1'b1) gos++;
      step();
    end
    vec_cnt++;
    if (gos != 0 || overrun_cnt !== exp_ovr) begin
      miscmp_cnt++;
      $display("FAIL enable_low_ignored: got activity=%0d cnt=%0d, required 0 and %0d", gos, overrun_cnt, exp_ovr);
    end
    enable = 1'b1;
    send_sample(16'h2222, 16'h4000, 16'h3333, 16'h0800);
    enable = 1'b0;
    wait_go(c);
    vec_cnt++;
    if (c != 2 || fir_x !== 16'h2222 || fir_wadj !== 16'h0400) begin
      miscmp_cnt++;
      $display("FAIL enable_mid_run: got go_cycle=%0d x=%h w=%h, required 2 2222 0400", c, fir_x, fir_wadj);
    end
    finish_run(15, 16'h6789, 1'b1);
    vec_cnt++;
    if (spk_valid !== 1'b1 || spk_out !== 16'h6789) begin
      miscmp_cnt++;
      $display("FAIL enable_mid_complete: got sv=%b spk=%h, required 1 6789", spk_valid, spk_out);
    end
    enable = 1'b1;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_overrun();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_enable();
    step();
    step();
    vec_cnt++;
    if (exp_q.size() != 0) begin
      miscmp_cnt++;
      $display("FAIL scoreboard_drain: got %0d results still pending, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule

// File: doc/anc_ctrl.md
# anc_ctrl

Sample-rate sequencer that sits directly upstream of the adaptive FIR engine and drives its `fir_go`/`done` handshake. Per accepted sample pair (reference mic, error mic) it:
- computes the LMS weight step `mu*err` (Q1.15, saturated);
- presents `x`, `a` and the weight step to the FIR and launches one run;
- waits for completion and forwards the FIR result to the speaker path.

It also counts dropped samples and detects a hung FIR.

## Interface
Parameters:
- `TIMEOUT`, 512: maximum cycles in WAIT before abort. Must exceed FIR run length, which is TAPS+7 = 263 for the default 256 taps.
- `CW`, 16: width of the overrun counter.

Ports:
- `clk`  in  1  single clock for the block.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  when low, IDLE ignores `smp_valid`.
- `smp_valid`  in  1  one-cycle strobe; `ref_in`, `err_in`, `mix_in` are valid in that cycle.
- `ref_in`  in  16  reference sample, signed Q1.15.
- `err_in`  in  16  error-mic sample, signed Q1.15.
- `mix_in`  in  16  passthrough/bias sample, signed Q1.15; becomes the FIR accumulator seed.
- `mu`  in  16  signed Q1.15 step size; sampled together with `err_in`.
- `fir_x`  out  16  to FIR `x_in`.
- `fir_a`  out  16  to FIR `a_in`.
- `fir_wadj`  out  16  to FIR `weight_adjust`.
- `fir_go`  out  1  one-cycle start pulse.
- `fir_out`  in  16  FIR `out_sample`.
- `fir_out_valid`  in  1  FIR `out_valid`.
- `fir_done`  in  1  FIR `done`.
- `spk_out`  out  16  last good FIR result.
- `spk_valid`  out  1  one-cycle strobe.
- `busy`  out  1  high in any state other than IDLE.
- `overrun`  out  1  one-cycle pulse when a sample is dropped.
- `overrun_cnt`  out  CW  dropped-sample count; saturates at all-ones.
- `timeout_err`  out  1  sticky; cleared only by reset.

## Operation
States:
- **IDLE**: if `smp_valid` and `enable`:
  - latch `ref_in`, `err_in`, `mix_in`, `mu`;
  - go to MUL.
- **MUL**: register `wadj = sat16((mu*err) >>> 15)` from the full 32-bit signed product.
  - Range clips to [0x8000, 0x7FFF]; 0x8000*0x8000 gives 0x7FFF.
  - Go to GO.
- **GO**: assert `fir_go` for exactly one cycle.
  - Clear the timeout counter.
  - Go to WAIT.
- **WAIT**: increment the timeout counter each cycle.
  - On `fir_done`: capture `fir_out` if `fir_out_valid` is high, then go to IDLE.
  - On counter reaching `TIMEOUT`: set `timeout_err`, go to IDLE, no `spk_valid`.

Output and counter rules:
- `fir_x`, `fir_a`, `fir_wadj` hold stable from GO until the next accepted sample's GO.
  - `fir_x` = latched `ref_in`; `fir_a` = latched `mix_in`.
- Overrun:
  - `smp_valid` while `busy` drops the sample.
  - It pulses `overrun` and increments `overrun_cnt`; the counter saturates.
  - `smp_valid` with `enable` low in IDLE is ignored and not counted.
- `enable` deasserted mid-run: the current run completes normally.
- `fir_done` seen outside WAIT (e.g. a late done after timeout) is ignored.
- `mu = 0` gives `wadj = 0`, which freezes adaptation; the output path is unaffected.

## Timing
- Reset values: all outputs 0, state IDLE, `timeout_err` 0, `overrun_cnt` 0.
- Reset mid-run returns to IDLE immediately. `fir_go` must not pulse again until a new sample is accepted.
- Latency, with the sample accepted at cycle 0:
  - MUL at cycle 1; `fir_go` high in cycle 2; WAIT from cycle 3.
  - With `fir_done` sampled high at cycle d: `spk_out`/`spk_valid` are registered at d+1, and `busy` is low at d+1.
  - A `smp_valid` in cycle d+1 is accepted.
  - A `smp_valid` in cycle d (WAIT) is dropped and counted.
- Throughput: one sample per (FIR run + 3) cycles.
- `spk_out` holds its value between strobes and after a timeout.

## Structure
- Shared package `anc_pkg`:
  - state enum (IDLE, MUL, GO, WAIT);
  - `Q15_MAX = 16'sh7FFF` and `Q15_MIN = 16'sh8000`;
  - default `TIMEOUT`.
- Sub-modules: reuse the existing `bw_mult` (16x16 signed) for `mu*err`, and the existing `saturate #(17,16)` on product bits [31:15].
- No new sub-module.

## Test plan
- Basic run:
  - Stimulus: reset; `ref=0x4000`, `err=0x2000`, `mu=0x4000`, `mix=0x0100`; FIR stub asserts `done` with `out=0x1234` 263 cycles after `fir_go`.
  - Required: `fir_wadj=0x1000`, `fir_x=0x4000`, `fir_a=0x0100`; `fir_go` exactly in cycle 2; `spk_out=0x1234` with `spk_valid` one cycle after `done`.
- Saturation:
  - `mu=0x8000`, `err=0x8000` -> `fir_wadj=0x7FFF`.
  - `mu=0x7FFF`, `err=0x8000` -> `fir_wadj=0x8001`.
- Overrun:
  - Stimulus: `smp_valid` at cycles 10 and 100 during a run, plus one in the `done` cycle.
  - Required: three `overrun` pulses, `overrun_cnt=3`, latched data unchanged.
  - A `smp_valid` in cycle d+1 is accepted.
- Timeout:
  - Stimulus: stub never asserts `done`.
  - Required: `timeout_err=1` after 512 WAIT cycles, `busy` low, no `spk_valid`.
  - A later stray `done` has no effect; the next sample runs normally.
- Reset mid-WAIT:
  - Stimulus: `rst_n` pulsed low.
  - Required: all outputs 0 asynchronously, no `fir_go` until a new `smp_valid`.
- Enable low:
  - Stimulus: `smp_valid` with `enable=0` in IDLE.
  - Required: no `fir_go`, `overrun_cnt` unchanged.
